// File: rtl/bp_pkg.sv
// Shared types and constants for the next-PC / branch-recovery logic.
package bp_pkg;

   localparam logic [31:0] DEFAULT_RESET_PC = 32'h0040_0000;
   localparam logic [31:0] PC_STEP          = 32'd4;

   // Recovery FSM: RECOVER lasts one non-stalled cycle after a redirect
   typedef enum logic [0:0] {
      ST_RUN     = 1'b0,
      ST_RECOVER = 1'b1
   } npc_state_e;

   // Prediction made at fetch time, carried one stage to meet the ID instruction
   typedef struct packed {
      logic        valid;
      logic        pred_taken;
      logic [31:0] pred_target;
      logic [31:0] pc;
   } pred_rec_t;

   // PC arithmetic wraps modulo 2^32
   function automatic logic [31:0] pc_add(input logic [31:0] pc, input logic [31:0] ofs);
      return pc + ofs;
   endfunction

endpackage

// File: rtl/sat_counter32.sv
// 32-bit event counter that sticks at all-ones instead of wrapping.
module sat_counter32 (
   input  logic        clk,
   input  logic        rst,
   input  logic        inc,
   output logic [31:0] count
);

   logic [31:0] count_r;

   // Count one per inc pulse, holding once the maximum is reached
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         count_r <= 32'd0;
      end else if (inc && (count_r != 32'hFFFF_FFFF)) begin
         count_r <= count_r + 32'd1;
      end else begin
         count_r <= count_r;
      end
   end

   assign count = count_r;

endmodule

// File: rtl/next_pc_unit.sv
// Fetch PC generation with BTB prediction, ID-stage resolution and
// one-cycle mispredict recovery (flush pulse plus redirect).
module next_pc_unit
   import bp_pkg::*;
#(
   parameter logic [31:0] RESET_PC     = DEFAULT_RESET_PC,
   parameter logic [31:0] FALLTHRU_OFS = 32'd4
) (
   input  logic        CLK,
   input  logic        RESET,
   input  logic        STALL,
   input  logic        hit_BTB,
   input  logic [31:0] take_Alt_PC_IN_IF,
   input  logic        Valid_IN_ID,
   input  logic [31:0] Instr_PC_IN_ID,
   input  logic        is_Branch_IN_ID,
   input  logic        is_Taken_IN_ID,
   input  logic [31:0] Alt_PC_IN_ID,
   output logic [31:0] Instr_PC_OUT_IF,
   output logic        Flush_OUT_IF,
   output logic        Mispredict_OUT,
   output logic [31:0] Branch_Count_OUT,
   output logic [31:0] Mispred_Count_OUT
);

   npc_state_e  state_r;
   npc_state_e  state_next_s;
   pred_rec_t   rec_r;
   pred_rec_t   rec_capture_s;
   logic [31:0] pc_r;
   logic [31:0] pc_next_s;
   logic [31:0] actual_next_s;
   logic        rec_trusted_s;
   logic        eval_s;
   logic        actual_taken_s;
   logic        target_wrong_s;
   logic        mispredict_s;
   logic        branch_inc_s;
   logic        pulse_r;

   // FSM state register; frozen while stalled
   always_ff @(posedge CLK or posedge RESET) begin
      if (RESET) begin
         state_r <= ST_RUN;
      end else if (!STALL) begin
         state_r <= state_next_s;
      end else begin
         state_r <= state_r;
      end
   end

   // FSM next state: enter RECOVER on a mispredict, leave after one live cycle
   always_comb begin
      state_next_s = state_r;
      case (state_r)
         ST_RUN: begin
            if (mispredict_s) begin
               state_next_s = ST_RECOVER;
            end else begin
               state_next_s = ST_RUN;
            end
         end
         ST_RECOVER: state_next_s = ST_RUN;
         default:    state_next_s = ST_RUN;
      endcase
   end

   // FSM output: the record held during RECOVER belongs to the flushed slot
   always_comb begin
      rec_trusted_s = 1'b0;
      case (state_r)
         ST_RUN:     rec_trusted_s = 1'b1;
         ST_RECOVER: rec_trusted_s = 1'b0;
         default:    rec_trusted_s = 1'b0;
      endcase
   end

   // Resolve the ID instruction against the prediction made when it was fetched
   always_comb begin
      actual_taken_s = is_Branch_IN_ID & is_Taken_IN_ID;
      if (actual_taken_s) begin
         actual_next_s = Alt_PC_IN_ID;
      end else begin
         actual_next_s = pc_add(Instr_PC_IN_ID, FALLTHRU_OFS);
      end
      eval_s = Valid_IN_ID & rec_r.valid & rec_trusted_s &
               (rec_r.pc == Instr_PC_IN_ID) & ~STALL;
      target_wrong_s = rec_r.pred_taken & actual_taken_s &
                       (rec_r.pred_target != Alt_PC_IN_ID);
      mispredict_s = eval_s & ((rec_r.pred_taken != actual_taken_s) | target_wrong_s);
      branch_inc_s = eval_s & is_Branch_IN_ID;
   end

   // Next fetch PC: redirect beats BTB target beats sequential
   always_comb begin
      if (mispredict_s) begin
         pc_next_s = actual_next_s;
      end else if (hit_BTB) begin
         pc_next_s = take_Alt_PC_IN_IF;
      end else begin
         pc_next_s = pc_add(pc_r, PC_STEP);
      end
   end

   // Prediction record for the PC being fetched this cycle
   always_comb begin
      rec_capture_s.valid       = 1'b1;
      rec_capture_s.pred_taken  = hit_BTB;
      rec_capture_s.pred_target = take_Alt_PC_IN_IF;
      rec_capture_s.pc          = pc_r;
   end

   // Fetch PC and prediction record advance together unless stalled
   always_ff @(posedge CLK or posedge RESET) begin
      if (RESET) begin
         pc_r  <= RESET_PC;
         rec_r <= '{valid: 1'b0, pred_taken: 1'b0, pred_target: 32'd0, pc: 32'd0};
      end else if (!STALL) begin
         pc_r  <= pc_next_s;
         rec_r <= rec_capture_s;
      end else begin
         pc_r  <= pc_r;
         rec_r <= rec_r;
      end
   end

   // Flush/mispredict pulse: mispredict is already gated by STALL, so never stretches
   always_ff @(posedge CLK or posedge RESET) begin
      if (RESET) begin
         pulse_r <= 1'b0;
      end else begin
         pulse_r <= mispredict_s;
      end
   end

   sat_counter32 u_branch_cnt (
      .clk   (CLK),
      .rst   (RESET),
      .inc   (branch_inc_s),
      .count (Branch_Count_OUT)
   );

   sat_counter32 u_mispred_cnt (
      .clk   (CLK),
      .rst   (RESET),
      .inc   (mispredict_s),
      .count (Mispred_Count_OUT)
   );

   assign Instr_PC_OUT_IF = pc_r;
   assign Flush_OUT_IF    = pulse_r;
   assign Mispredict_OUT  = pulse_r;

endmodule

// File: doc/next_pc_unit.md
NEXT_PC_UNIT -- requirements
Module: next_pc_unit

Interface
REQ-001 SHALL have parameter RESET_PC, default 32'h00400000, meaning the first fetch address after reset.
REQ-002 SHALL have parameter FALLTHRU_OFS, default 32'd4, meaning the offset added to the ID PC for a not-taken branch.
REQ-003 SHALL have port CLK  input  1  system clock.
REQ-004 SHALL have port RESET  input  1  reset; one clock, reset asynchronous and active-high.
REQ-005 SHALL have port STALL  input  1  freezes all state when 1.
REQ-006 SHALL have port hit_BTB  input  1  BTB hit for the current fetch PC.
REQ-007 SHALL have port take_Alt_PC_IN_IF  input  32  BTB predicted target.
REQ-008 SHALL have port Valid_IN_ID  input  1  ID holds a live instruction.
REQ-009 SHALL have port Instr_PC_IN_ID  input  32  PC of the ID instruction.
REQ-010 SHALL have port is_Branch_IN_ID  input  1  ID instruction is a branch or jump.
REQ-011 SHALL have port is_Taken_IN_ID  input  1  resolved direction.
REQ-012 SHALL have port Alt_PC_IN_ID  input  32  resolved taken target.
REQ-013 SHALL have port Instr_PC_OUT_IF  output  32  current fetch PC.
REQ-014 SHALL have port Flush_OUT_IF  output  1  one-cycle kill of the IF/ID instruction.
REQ-015 SHALL have port Mispredict_OUT  output  1  one-cycle mispredict pulse.
REQ-016 SHALL have port Branch_Count_OUT  output  32  resolved branches.
REQ-017 SHALL have port Mispred_Count_OUT  output  32  mispredictions.

Function
REQ-018 SHALL register the fetch PC; when STALL=0, next PC priority SHALL be: redirect target, then take_Alt_PC_IN_IF if hit_BTB, else PC+4, wrapping modulo 2^32.
REQ-019 SHALL capture a prediction record {valid, pred_taken=hit_BTB, pred_target, pc} each non-stalled cycle, advancing it one stage to align with ID; the record SHALL hold while STALL=1.
REQ-020 SHALL evaluate only when Valid_IN_ID=1, record valid=1, record pc==Instr_PC_IN_ID, and STALL=0.
REQ-021 SHALL compute actual_taken = is_Branch_IN_ID & is_Taken_IN_ID; actual_next = Alt_PC_IN_ID if actual_taken, else Instr_PC_IN_ID+FALLTHRU_OFS.
REQ-022 SHALL flag a mispredict when pred_taken!=actual_taken, or both are 1 and pred_target!=Alt_PC_IN_ID; pred_taken=1 on a non-branch SHALL be a mispredict.
REQ-023 On a mispredict, the next PC SHALL be actual_next; Flush_OUT_IF and Mispredict_OUT SHALL be 1 for exactly the following cycle.
REQ-024 FSM states: RUN and RECOVER; RUN->RECOVER on a mispredict; RECOVER->RUN after one non-stalled cycle. In RECOVER the captured record SHALL be marked invalid, so no evaluation occurs on the flushed slot.
REQ-025 STALL=1 coincident with mispredict conditions SHALL defer the redirect until the first STALL=0 cycle, with inputs held; no pulse SHALL occur while stalled.
REQ-026 Branch_Count_OUT SHALL increment on each evaluation with is_Branch_IN_ID=1; Mispred_Count_OUT SHALL increment on each mispredict; both SHALL saturate at 32'hFFFFFFFF.
REQ-027 A mispredict and a BTB hit in the same cycle SHALL resolve to the redirect; the BTB target SHALL be discarded.

Reset
REQ-028 RESET=1 SHALL asynchronously set Instr_PC_OUT_IF=RESET_PC, record valid=0, state=RUN, Flush_OUT_IF=0, Mispredict_OUT=0, and both counters=0.
REQ-029 Reset asserted mid-recovery SHALL abandon the pending redirect; after release the first fetch SHALL be RESET_PC.

Structure
REQ-030 State encoding (RUN, RECOVER), prediction-record struct and default RESET_PC SHALL live in shared package bp_pkg.
REQ-031 Saturating counters SHALL be one sub-module, sat_counter32, instantiated twice.

Verification
REQ-032 Reset release, no BTB hit, 3 cycles -> PC 00400000, 00400004, 00400008; counters 0.
REQ-033 hit_BTB=1 with target 00400100 at PC 00400008 -> next PC 00400100; ID resolves taken to 00400100 -> no flush; Branch_Count=1.
REQ-034 Predicted not-taken at 00400010; ID taken, Alt_PC=00400200 -> next PC 00400200, Flush and Mispredict pulse 1 cycle, Mispred_Count=1, next ID slot not evaluated.
REQ-035 Predicted taken to 00400300; ID taken to 00400400 -> redirect to 00400400, mispredict counted.
REQ-036 Mispredict conditions with STALL=1 for 3 cycles -> PC frozen, no pulse; on release, redirect and single pulse.
REQ-037 RESET asserted during RECOVER -> immediate PC=00400000, outputs 0, no later redirect.
